// File: rtl/psram_pkg.sv
// -----------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the device-side PSRAM loopback responder:
//   - command opcodes recognised in the command cycle
//   - responder FSM state encoding
//   - data word width (one hi/lo beat pair) and byte-lane count
// -----------------------------------------------------------------------------
package psram_pkg;

   localparam logic [7:0]  CMD_SYNC_RD = 8'h20;
   localparam logic [7:0]  CMD_SYNC_WR = 8'hA0;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned NBYTES  = WORD_W / 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WLAT,
      WDATA,
      RLAT,
      RDATA,
      IGNORE
   } state_e;

endpackage

// File: rtl/psram_resp_mem.sv
// -----------------------------------------------------------------------------
// psram_resp_mem
// Single-port synchronous RAM, 2^ADDR_WIDTH x 32 bits, with per-byte write
// enables. Read-first behaviour; read data is registered (one-cycle latency).
// Written to map onto block RAM.
// Ports:
//   clk_i    : clock
//   addr_i   : word address (read and write)
//   we_i     : write enable
//   be_i     : byte enables, bit n covers wdata_i[8n+7:8n]
//   wdata_i  : write data
//   rdata_o  : registered read data of mem[addr_i] from the previous edge
// -----------------------------------------------------------------------------
module psram_resp_mem
   import psram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [NBYTES-1:0]     be_i,
   input  logic [WORD_W-1:0]     wdata_i,
   output logic [WORD_W-1:0]     rdata_o
);

   logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_responder.sv
// -----------------------------------------------------------------------------
// psram_responder
// Device end of the x16 PSRAM protocol for on-FPGA loopback: decodes the
// command/address cycles, applies fixed read/write latency and runs linear,
// wrapping bursts into an internal RAM. One ram_clk cycle = one 32-bit word
// ({hi,lo} beat pair).
// Build option: define PSRAM_RESP_MASK_EN to honour dm_out_* byte masks;
// otherwise all four bytes are written on every beat.
// Ports:
//   ram_clk            : clock
//   rst                : asynchronous active-high reset
//   psram_ce           : chip enable, active-low
//   dq_out_hi/lo       : controller data (command, address, write data)
//   dm_out_hi/lo       : controller write masks, 1 = byte masked
//   dq_in_hi/lo        : read data, zero when not driving
//   dm_in_hi/lo        : read strobe, 2'b11 / 2'b00 while driving
//   rd_oe              : responder is driving read data and strobe
// -----------------------------------------------------------------------------
module psram_responder
   import psram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned RD_LATENCY = 4,
   parameter int unsigned WR_LATENCY = 2
) (
   input  logic        ram_clk,
   input  logic        rst,
   input  logic        psram_ce,
   input  logic [15:0] dq_out_hi,
   input  logic [15:0] dq_out_lo,
   input  logic [1:0]  dm_out_hi,
   input  logic [1:0]  dm_out_lo,
   output logic [15:0] dq_in_hi,
   output logic [15:0] dq_in_lo,
   output logic [1:0]  dm_in_hi,
   output logic [1:0]  dm_in_lo,
   output logic        rd_oe
);

   localparam int unsigned LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

   // Latency states last (LATENCY-1) cycles, counted down to zero.
   localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 2);
   localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'((WR_LATENCY >= 2) ? (WR_LATENCY - 2) : 0);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              cmd_q, cmd_d;
   logic                    rd_oe_q, rd_oe_d;

   logic                    mem_we;
   logic [NBYTES-1:0]       mem_be;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [WORD_W-1:0]       mem_rdata;

   always_ff @(posedge ram_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         cmd_q   <= '0;
         rd_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         rd_oe_q <= rd_oe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      mem_we  = 1'b0;

      if (psram_ce && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!psram_ce) begin
                  cmd_d   = dq_out_hi[7:0];
                  state_d = ADDR;
               end
            end
            ADDR: begin
               addr_d = ADDR_WIDTH'({dq_out_hi, dq_out_lo});
               if (cmd_q == CMD_SYNC_WR) begin
                  if (WR_LATENCY == 1) begin
                     state_d = WDATA;
                  end else begin
                     state_d = WLAT;
                     cnt_d   = WR_CNT_INIT;
                  end
               end else if (cmd_q == CMD_SYNC_RD) begin
                  state_d = RLAT;
                  cnt_d   = RD_CNT_INIT;
               end else begin
                  state_d = IGNORE;
               end
            end
            WLAT: begin
               if (cnt_q == '0) state_d = WDATA;
               else             cnt_d   = cnt_q - 1'b1;
            end
            RLAT: begin
               if (cnt_q == '0) state_d = RDATA;
               else             cnt_d   = cnt_q - 1'b1;
            end
            WDATA: begin
               mem_we = 1'b1;
               addr_d = addr_q + 1'b1;
            end
            RDATA: begin
               addr_d = addr_q + 1'b1;
            end
            IGNORE: begin
            end
            default: state_d = IDLE;
         endcase
      end

      rd_oe_d = (state_d == RDATA);
   end

   // Read data comes out of the RAM's output register, so each beat's address
   // is issued one cycle early: the last latency cycle issues addr_q, and each
   // RDATA cycle issues the following word.
   assign mem_addr = (state_q == RDATA) ? (addr_q + 1'b1) : addr_q;

`ifdef PSRAM_RESP_MASK_EN
   assign mem_be = ~{dm_out_hi, dm_out_lo};
`else
   logic unused_dm;
   assign unused_dm = ^{dm_out_hi, dm_out_lo};
   assign mem_be    = '1;
`endif

   psram_resp_mem #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (ram_clk),
      .addr_i  (mem_addr),
      .we_i    (mem_we),
      .be_i    (mem_be),
      .wdata_i ({dq_out_hi, dq_out_lo}),
      .rdata_o (mem_rdata)
   );

   // RAM output register is not reset; gating by rd_oe_q keeps outputs at zero
   // during and after reset.
   assign dq_in_hi = rd_oe_q ? mem_rdata[31:16] : '0;
   assign dq_in_lo = rd_oe_q ? mem_rdata[15:0]  : '0;
   assign dm_in_hi = {2{rd_oe_q}};
   assign dm_in_lo = 2'b00;
   assign rd_oe    = rd_oe_q;

endmodule

// File: tb/tb_psram_responder.sv
module tb_psram_responder;
   import psram_pkg::*;

   localparam int RL = 4;
   localparam int WL = 2;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [15:0] dq_hi, dq_lo;
   logic [1:0]  dm_hi, dm_lo;
   logic [15:0] q_hi, q_lo;
   logic [1:0]  s_hi, s_lo;
   logic        rd_oe;

   psram_responder #(
      .ADDR_WIDTH (AW),
      .RD_LATENCY (RL),
      .WR_LATENCY (WL)
   ) dut (
      .ram_clk   (clk),
      .rst       (rst),
      .psram_ce  (ce),
      .dq_out_hi (dq_hi),
      .dq_out_lo (dq_lo),
      .dm_out_hi (dm_hi),
      .dm_out_lo (dm_lo),
      .dq_in_hi  (q_hi),
      .dq_in_lo  (q_lo),
      .dm_in_hi  (s_hi),
      .dm_in_lo  (s_lo),
      .rd_oe     (rd_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      logic [1:0]  mhi;
      logic [1:0]  mlo;
      logic [31:0] exp;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model [1024];
   logic [31:0] exp_q [$];
   logic [31:0] wbuf [8];
   logic [1:0]  whi [8];
   logic [1:0]  wlo [8];
   vec_t        tbl [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      ce    = 1'b1;
      dq_hi = 16'hBAD0;
      dq_lo = 16'hBAD1;
      dm_hi = 2'b00;
      dm_lo = 2'b00;
   endtask

   // Command + address, WL-1 latency cycles, n beats from wbuf/whi/wlo, then
   // one CE-high cycle carrying junk data (must not be written).
   task automatic wr_burst(input logic [9:0] a, input int n);
      ce = 1'b0; dq_hi = {8'h00, CMD_SYNC_WR}; dq_lo = 16'h0000; dm_hi = 2'b00; dm_lo = 2'b00;
      tick();
      dq_hi = 16'h0000; dq_lo = {6'b0, a};
      tick();
      for (int i = 0; i < WL - 1; i++) begin
         dq_hi = 16'hEEEE; dq_lo = 16'hEEEE;
         tick();
      end
      for (int k = 0; k < n; k++) begin
         dq_hi = wbuf[k][31:16]; dq_lo = wbuf[k][15:0];
         dm_hi = whi[k];         dm_lo = wlo[k];
         chk("wr_rd_oe", {31'b0, rd_oe}, 32'd0);
         tick();
      end
      bus_idle();
      tick();
   endtask

   // Read n words; expectations must already be in exp_q.
   task automatic rd_burst(input logic [9:0] a, input int n);
      int lat;
      logic [31:0] e;
      ce = 1'b0; dq_hi = {8'h00, CMD_SYNC_RD}; dq_lo = 16'h0000;
      chk("rd_cmd_oe", {31'b0, rd_oe}, 32'd0);
      tick();
      dq_hi = 16'h0000; dq_lo = {6'b0, a};
      tick();
      dq_hi = 16'hEEEE; dq_lo = 16'hEEEE;
      lat = 1;
      while (rd_oe !== 1'b1 && lat < RL + 4) begin
         tick();
         lat++;
      end
      chk("rd_latency", 32'(lat), 32'(RL));
      for (int k = 0; k < n; k++) begin
         chk("rd_oe_beat", {31'b0, rd_oe}, 32'd1);
         chk("dm_in", {28'b0, s_hi, s_lo}, 32'h0000_000C);
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_scoreboard: got beat with empty queue expected none");
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", {q_hi, q_lo}, e);
         end
         tick();
      end
      bus_idle();
      tick();
      chk("rd_end_oe", {31'b0, rd_oe}, 32'd0);
      chk("rd_end_data", {q_hi, q_lo}, 32'd0);
   endtask

   task automatic push_model(input logic [9:0] a, input int n);
      logic [9:0] idx;
      for (int k = 0; k < n; k++) begin
         idx = a + 10'(k);
         exp_q.push_back(model[idx]);
      end
   endtask

   task automatic set_wbuf_model(input logic [9:0] a, input int n);
      logic [9:0] idx;
      for (int k = 0; k < n; k++) begin
         idx = a + 10'(k);
         model[idx] = wbuf[k];
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] e;

      tbl[0] = '{10'h100, 32'hAABBCCDD, 2'b10, 2'b01, 32'h00BBCC00};
      tbl[1] = '{10'h101, 32'h12345678, 2'b01, 2'b10, 32'h12000078};
      tbl[2] = '{10'h102, 32'hDEADBEEF, 2'b00, 2'b00, 32'hDEADBEEF};
      tbl[3] = '{10'h103, 32'hCAFEF00D, 2'b11, 2'b11, 32'h00000000};
`ifndef PSRAM_RESP_MASK_EN
      foreach (tbl[i]) tbl[i].exp = tbl[i].data;
`endif
      for (int k = 0; k < 8; k++) begin
         whi[k] = 2'b00;
         wlo[k] = 2'b00;
      end

      // Reset state
      bus_idle();
      rst = 1'b1;
      tick(); tick();
      chk("rst_oe", {31'b0, rd_oe}, 32'd0);
      chk("rst_data", {q_hi, q_lo}, 32'd0);
      chk("rst_dm", {28'b0, s_hi, s_lo}, 32'd0);
      rst = 1'b0;
      tick();

      // Basic 4-word burst at 0x010
      wbuf[0] = 32'h11112222; wbuf[1] = 32'h33334444;
      wbuf[2] = 32'h55556666; wbuf[3] = 32'h77778888;
      wr_burst(10'h010, 4);
      set_wbuf_model(10'h010, 4);
      push_model(10'h010, 4);
      rd_burst(10'h010, 4);

      // Byte-mask vectors over zero-filled words
      for (int k = 0; k < 4; k++) wbuf[k] = 32'h0;
      wr_burst(10'h100, 4);
      set_wbuf_model(10'h100, 4);
      foreach (tbl[i]) begin
         wbuf[0] = tbl[i].data; whi[0] = tbl[i].mhi; wlo[0] = tbl[i].mlo;
         wr_burst(tbl[i].addr, 1);
         exp_q.push_back(tbl[i].exp);
         rd_burst(tbl[i].addr, 1);
         model[tbl[i].addr] = tbl[i].exp;
      end
      whi[0] = 2'b00; wlo[0] = 2'b00;

      // Address wrap at the top of the RAM
      wbuf[0] = 32'hA0000001; wbuf[1] = 32'hA0000002; wbuf[2] = 32'hA0000003;
      wr_burst(10'h3FF, 3);
      set_wbuf_model(10'h3FF, 3);
      exp_q.push_back(32'hA0000002);
      exp_q.push_back(32'hA0000003);
      rd_burst(10'h000, 2);
      push_model(10'h3FF, 3);
      rd_burst(10'h3FF, 3);

      // Abort after 2 of 4 write beats, next transaction right after
      wbuf[0] = 32'h0A0A0A0A; wbuf[1] = 32'h0B0B0B0B;
      wbuf[2] = 32'h0C0C0C0C; wbuf[3] = 32'h0D0D0D0D;
      wr_burst(10'h020, 4);
      set_wbuf_model(10'h020, 4);
      wbuf[0] = 32'hF1F1F1F1; wbuf[1] = 32'hF2F2F2F2;
      wr_burst(10'h020, 2);
      model[10'h020] = 32'hF1F1F1F1;
      model[10'h021] = 32'hF2F2F2F2;
      exp_q.push_back(32'hF1F1F1F1); exp_q.push_back(32'hF2F2F2F2);
      exp_q.push_back(32'h0C0C0C0C); exp_q.push_back(32'h0D0D0D0D);
      rd_burst(10'h020, 4);

      // Unknown command, CE low for 10 cycles
      ce = 1'b0; dq_hi = 16'h0055; dq_lo = 16'h0000;
      tick();
      dq_hi = 16'h0000; dq_lo = 16'h0010;
      for (int i = 1; i < 10; i++) begin
         chk("ign_oe", {31'b0, rd_oe}, 32'd0);
         tick();
         dq_hi = 16'(16'h9000 + i); dq_lo = 16'h9999;
      end
      bus_idle();
      tick();
      push_model(10'h010, 4);
      rd_burst(10'h010, 4);

      // Reset in the middle of a read burst
      push_model(10'h010, 4);
      ce = 1'b0; dq_hi = {8'h00, CMD_SYNC_RD}; dq_lo = 16'h0000;
      tick();
      dq_hi = 16'h0000; dq_lo = 16'h0010;
      tick();
      for (int i = 0; i < RL - 1; i++) tick();
      for (int k = 0; k < 2; k++) begin
         chk("rr_oe", {31'b0, rd_oe}, 32'd1);
         e = exp_q.pop_front();
         chk("rr_data", {q_hi, q_lo}, e);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("rr_rst_oe", {31'b0, rd_oe}, 32'd0);
      chk("rr_rst_data", {q_hi, q_lo}, 32'd0);
      chk("rr_rst_dm", {28'b0, s_hi, s_lo}, 32'd0);
      bus_idle();
      tick();
      rst = 1'b0;
      tick();
      exp_q.delete();
      push_model(10'h010, 4);
      rd_burst(10'h010, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
